// File: rtl/mem_arb.sv
// mem_arb: two-requester (instruction fetch / data) arbiter in front of a
// single-outstanding memory port.
//
// One transaction is in flight at a time. The FSM walks
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE. A misaligned request, when
// ALIGN_CHECK is set, goes straight from IDLE to RESP with an error and
// never reaches memory.
//
// Compile-time option:
//   MEM_ARB_RR_EN  defined   -> round-robin grant between the two ports
//                  undefined -> fixed priority, port 1 (data) wins
module mem_arb #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_val,
  output logic [1:0]  req_rdy,
  input  logic [1:0]  req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  resp_val,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_req_val,
  input  logic        mem_req_rdy,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_val,
  input  logic [31:0] mem_resp_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Port index -> one-hot strobe for the two requesters.
  function automatic logic [1:0] port_onehot(input logic port);
    port_onehot = port ? 2'b10 : 2'b01;
  endfunction

  // A word access must sit on a 4-byte boundary when checking is enabled.
  function automatic logic is_misaligned(input logic [31:0] addr);
    is_misaligned = ALIGN_CHECK && (addr[1:0] != 2'b00);
  endfunction

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        gnt_s;
  logic        accept_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_wen_s;

`ifdef MEM_ARB_RR_EN
  // 1 = port 1 wins the next contention, 0 = port 0 wins.
  logic        prio_q, prio_d;
`endif

  // Choose which requester would be granted this cycle.
  always_comb begin
    gnt_s = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (req_val == 2'b11) begin
      gnt_s = prio_q;
    end else if (req_val[1]) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
`else
    if (req_val[1]) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
`endif
  end

  // Ready only in IDLE, only to the granted and valid requester, never in reset.
  always_comb begin
    req_rdy = 2'b00;
    if ((state_q == ST_IDLE) && req_val[gnt_s] && rst) begin
      req_rdy = port_onehot(gnt_s);
    end else begin
      req_rdy = 2'b00;
    end
  end

  assign accept_s    = |(req_val & req_rdy);
  assign sel_addr_s  = gnt_s ? req_addr[63:32]  : req_addr[31:0];
  assign sel_wdata_s = gnt_s ? req_wdata[63:32] : req_wdata[31:0];
  assign sel_wen_s   = gnt_s ? req_wen[1]       : req_wen[0];

  // Transaction FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          owner_d = gnt_s;
          wen_d   = sel_wen_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          rdata_d = 32'd0;
          if (is_misaligned(sel_addr_s)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_req_rdy) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_resp_val) begin
          rdata_d = wen_q ? 32'd0 : mem_resp_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_RR_EN
  // After a grant, the other port gets priority on the next contention.
  always_comb begin
    prio_d = prio_q;
    if (accept_s) begin
      prio_d = ~gnt_s;
    end else begin
      prio_d = prio_q;
    end
  end

  // Round-robin pointer; reset favours the data port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  // State and latched-transaction registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory request decoded from flops; address/data are zero outside ISSUE.
  always_comb begin
    mem_req_val   = 1'b0;
    mem_req_wen   = 1'b0;
    mem_req_addr  = 32'd0;
    mem_req_wdata = 32'd0;
    if (state_q == ST_ISSUE) begin
      mem_req_val   = 1'b1;
      mem_req_wen   = wen_q;
      mem_req_addr  = addr_q;
      mem_req_wdata = wdata_q;
    end else begin
      mem_req_val   = 1'b0;
    end
  end

  // Response strobe to the owner for the single RESP cycle; data/err zero otherwise.
  always_comb begin
    resp_val  = 2'b00;
    resp_data = 32'd0;
    resp_err  = 1'b0;
    if (state_q == ST_RESP) begin
      resp_val  = port_onehot(owner_q);
      resp_data = rdata_q;
      resp_err  = err_q;
    end else begin
      resp_val  = 2'b00;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed requests push expected responses,
// a monitor pops and compares whenever resp_val is seen, and a small memory
// model serves the memory port with programmable ready/response delays.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_val;
  logic [1:0]  req_rdy;
  logic [1:0]  req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  resp_val;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_val;
  logic [31:0] mem_resp_data;

  mem_arb dut (
    .clk           (clk),
    .rst           (rst),
    .req_val       (req_val),
    .req_rdy       (req_rdy),
    .req_wen       (req_wen),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_val      (resp_val),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_wen   (mem_req_wen),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_data (mem_resp_data)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];

  int total;
  int bad;
  int cyc;
  int last_accept;

  // memory model controls/state
  int          rdy_hold;
  int          resp_lat;
  int          hold_cnt;
  int          resp_cnt;
  int          memreq_seen;
  bit          in_req;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_wen;
  logic [31:0] resp_word;
  logic [31:0] mem [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // memory model: holds ready low rdy_hold cycles, answers resp_lat cycles later
  initial begin
    mem_req_rdy   = 1'b0;
    mem_resp_val  = 1'b0;
    mem_resp_data = 32'd0;
    hold_cnt      = 0;
    resp_cnt      = 0;
    in_req        = 1'b0;
    memreq_seen   = 0;
    forever begin
      @(negedge clk);
      mem_resp_val = 1'b0;
      mem_req_rdy  = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_val  = 1'b1;
          mem_resp_data = resp_word;
        end
      end
      if (mem_req_val) begin
        memreq_seen++;
        if (!in_req) begin
          in_req    = 1'b1;
          hold_cnt  = 0;
          cap_addr  = mem_req_addr;
          cap_wdata = mem_req_wdata;
          cap_wen   = mem_req_wen;
          check("mem_req_latency", cyc, last_accept + 1);
        end else begin
          check("mem_addr_stable",  mem_req_addr,  cap_addr);
          check("mem_wdata_stable", mem_req_wdata, cap_wdata);
          check("mem_wen_stable",   {31'd0, mem_req_wen}, {31'd0, cap_wen});
        end
        if (hold_cnt >= rdy_hold) begin
          mem_req_rdy = 1'b1;
          in_req      = 1'b0;
          resp_cnt    = resp_lat;
          if (cap_wen) begin
            mem[cap_addr] = cap_wdata;
            resp_word     = 32'hCAFEF00D;
          end else if (mem.exists(cap_addr)) begin
            resp_word = mem[cap_addr];
          end else begin
            resp_word = 32'h0BADF00D;
          end
        end else begin
          hold_cnt++;
        end
      end
    end
  end

  // monitor: pops the scoreboard whenever a response strobe appears
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("rdy_at_most_one", {31'd0, ($countones(req_rdy) <= 1)}, 32'd1);
      if (resp_val != 2'b00) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp_val=%b data=%h err=%b want none (cyc %0d)",
                   resp_val, resp_data, resp_err, cyc);
        end else begin
          e = sb.pop_front();
          check("resp_val",     {30'd0, resp_val}, (e.port == 1) ? 32'd2 : 32'd1);
          check("resp_data",    resp_data, e.data);
          check("resp_err",     {31'd0, resp_err}, {31'd0, e.err});
          check("resp_latency", cyc, e.due);
        end
      end else begin
        check("idle_resp_data", resp_data, 32'd0);
        check("idle_resp_err",  {31'd0, resp_err}, 32'd0);
      end
    end
  end

  // issue one request and push its expected response with hand-computed latency
  task automatic issue(input int port, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input int lat);
    bit got;
    exp_t e;
    got = 1'b0;
    @(posedge clk);
    #1;
    req_val[port]             = 1'b1;
    req_wen[port]             = wen;
    req_addr[32*port +: 32]   = addr;
    req_wdata[32*port +: 32]  = wdata;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_rdy[port]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no req_rdy want req_rdy[%0d] (cyc %0d)", port, cyc);
    end else begin
      last_accept = cyc;
      e.port = port;
      e.data = exp_data;
      e.err  = exp_err;
      e.due  = cyc + lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    req_val[port] = 1'b0;
  endtask

  // wait (bounded) for all expected responses to arrive
  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"},       {30'd0, req_rdy},  32'd0);
    check({tag, "_resp_val"},      {30'd0, resp_val}, 32'd0);
    check({tag, "_resp_data"},     resp_data,         32'd0);
    check({tag, "_resp_err"},      {31'd0, resp_err}, 32'd0);
    check({tag, "_mem_req_val"},   {31'd0, mem_req_val}, 32'd0);
    check({tag, "_mem_req_wen"},   {31'd0, mem_req_wen}, 32'd0);
    check({tag, "_mem_req_addr"},  mem_req_addr,  32'd0);
    check({tag, "_mem_req_wdata"}, mem_req_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100000");
    $fatal(1, "watchdog");
  end

  int   expg[4];
  int   seen0;
  bit   got;
  logic g;

  initial begin
`ifdef MEM_ARB_RR_EN
    expg = '{1, 0, 1, 0};
`else
    expg = '{1, 1, 1, 1};
`endif
    total       = 0;
    bad         = 0;
    cyc         = 0;
    last_accept = 0;
    rdy_hold    = 0;
    resp_lat    = 1;
    rst         = 1'b0;
    req_val     = 2'b00;
    req_wen     = 2'b00;
    req_addr    = 64'd0;
    req_wdata   = 64'd0;
    mem[32'h0000_0100] = 32'hDEADBEEF;
    mem[32'h0000_0300] = 32'h5A5A0300;
    mem[32'h0000_0400] = 32'hA5A50400;

    // reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // port 0 read, fast memory: response 3 cycles after accept
    rdy_hold = 0; resp_lat = 1;
    issue(0, 1'b0, 32'h0000_0100, 32'd0, 32'hDEADBEEF, 1'b0, 3);
    drain();

    // port 1 write with ready held low 3 cycles
    rdy_hold = 3; resp_lat = 1;
    issue(1, 1'b1, 32'h0000_0204, 32'h12345678, 32'd0, 1'b0, 6);
    drain();

    // port 0 reads back the written word, response two cycles after mem accept
    rdy_hold = 0; resp_lat = 2;
    issue(0, 1'b0, 32'h0000_0204, 32'd0, 32'h12345678, 1'b0, 4);
    drain();

    // misaligned read on port 1: error one cycle after accept, memory untouched
    seen0 = memreq_seen;
    rdy_hold = 0; resp_lat = 1;
    issue(1, 1'b0, 32'h0000_0102, 32'd0, 32'd0, 1'b1, 1);
    drain();
    check("misalign_rd_no_mem", memreq_seen, seen0);

    // misaligned write on port 0
    issue(0, 1'b1, 32'h0000_0003, 32'h55AA55AA, 32'd0, 1'b1, 1);
    drain();
    check("misalign_wr_no_mem", memreq_seen, seen0);
    check("misalign_wr_no_store", {31'd0, mem.exists(32'h0000_0003)}, 32'd0);

    // both ports valid continuously for 4 transactions
    @(posedge clk);
    #1;
    req_val   = 2'b11;
    req_wen   = 2'b00;
    req_addr  = {32'h0000_0400, 32'h0000_0300};
    req_wdata = 64'd0;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (req_rdy != 2'b00) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL grant_timeout: got no req_rdy want grant %0d", i);
        break;
      end
      g = req_rdy[1];
      check("grant", {31'd0, g}, expg[i]);
      last_accept = cyc;
      e.port = expg[i];
      e.data = (expg[i] == 1) ? 32'hA5A50400 : 32'h5A5A0300;
      e.err  = 1'b0;
      e.due  = cyc + 3;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    req_val = 2'b00;
    drain();

    // reset pulsed while in WAIT; late memory response must be ignored
    rdy_hold = 0; resp_lat = 6;
    @(posedge clk);
    #1;
    req_val[0]       = 1'b1;
    req_wen[0]       = 1'b0;
    req_addr[31:0]   = 32'h0000_0100;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_rdy[0]) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_test_accept", {31'd0, got}, 32'd1);
    last_accept = cyc;
    @(posedge clk);
    #1;
    req_val = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_test_in_wait", {31'd0, mem_req_val}, 32'd0);
    rst     = 1'b0;
    req_val = 2'b01;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst     = 1'b1;
    req_val = 2'b00;
    repeat (10) @(negedge clk);
    check("rst_late_resp_consumed", resp_cnt, 0);

    // next request completes normally after the reset
    rdy_hold = 0; resp_lat = 1;
    issue(1, 1'b0, 32'h0000_0400, 32'd0, 32'hA5A50400, 1'b0, 3);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
